// File: rtl/flash_bus_pkg.sv
// Types and constants shared between the 6809 bus bridge and the SPI flash engine.
package flash_bus_pkg;

  localparam int FLASH_ADDR_W = 24;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam logic [7:0] FLASH_CMD_PP   = 8'h02;
  localparam logic [7:0] FLASH_CMD_WREN = 8'h06;
  localparam logic [7:0] FLASH_CMD_RDSR = 8'h05;

  // Byte returned to the CPU when a read is forced complete by the timeout.
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DRAIN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_HOLD
  } bridge_state_t;

  typedef struct packed {
    logic                    rw;
    logic [FLASH_ADDR_W-1:0] addr;
    logic [7:0]              data;
  } flash_req_t;

endpackage

// File: rtl/bus_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus strobe, with rise/fall pulses.
module bus_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/flash_bus_bridge.sv
// 6809 bus front end for the SPI flash engine: stretched reads, posted writes
// through a one-entry buffer, and a timeout guard on every accepted request.
module flash_bus_bridge
  import flash_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'hE000,
  parameter int          WINDOW_BITS    = 12,
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enable,
  input  logic                    i_Q,
  input  logic                    i_RW,
  input  logic [15:0]             i_ADDRESS_BUS,
  input  logic [7:0]              i_DataBus,
  output logic                    o_req_valid,
  output logic                    o_req_rw,
  output logic [FLASH_ADDR_W-1:0] o_req_addr,
  output logic [7:0]              o_req_data,
  input  logic                    i_req_ready,
  input  logic                    i_done,
  input  logic [7:0]              i_rdata,
  output logic [7:0]              o_spi_data,
  output logic                    o_data_oe,
  output logic                    o_MemoryReady,
  output logic                    o_timeout
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic e_lvl, e_rise, e_fall;
  logic q_lvl, q_rise, q_fall;
  logic rw_lvl, rw_rise, rw_fall;
  logic unused_ok;

  bus_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_e (
    .clk(clk), .reset(reset), .async_in(i_enable),
    .level(e_lvl), .rise(e_rise), .fall(e_fall));
  bus_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_q (
    .clk(clk), .reset(reset), .async_in(i_Q),
    .level(q_lvl), .rise(q_rise), .fall(q_fall));
  bus_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rw (
    .clk(clk), .reset(reset), .async_in(i_RW),
    .level(rw_lvl), .rise(rw_rise), .fall(rw_fall));

  assign unused_ok = ^{e_rise, e_fall, q_lvl, rw_rise, rw_fall};

  bridge_state_t          state, state_n;
  logic [WINDOW_BITS-1:0] rd_addr, wb_addr, off;
  logic [7:0]             wb_data;
  logic                   wb_full, wr_stall, wr_qfell;
  logic                   busy, busy_rw;
  logic [CNT_W-1:0]       cnt;
  logic hit, accept, done_ok, tmo_hit, cmpl, rd_cmpl, wr_clear, wb_free;
  logic cap_post, cap_stall, capture, stall_set;
  logic rd_latch, rd_mrdy_clr, rd_mrdy_set, spi_load, oe_n;

  assign hit = (i_ADDRESS_BUS[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS]);
  assign off = i_ADDRESS_BUS[WINDOW_BITS-1:0];

  // Valid and busy are mutually exclusive: a request is either offered or in flight.
  assign accept   = o_req_valid & i_req_ready;
  assign done_ok  = busy & i_done;
  assign tmo_hit  = busy & ~i_done & (cnt == CNT_MAX);
  assign cmpl     = done_ok | tmo_hit;
  assign rd_cmpl  = cmpl & busy_rw;
  assign wr_clear = cmpl & ~busy_rw;
  assign wb_free  = ~wb_full | wr_clear;

  // A Q-fall seen while stretched is remembered so the deferred capture cannot
  // miss its strobe if the buffer drains after Q has already dropped.
  assign cap_post  = q_fall & hit & ~rw_lvl & wb_free & ~wr_stall;
  assign stall_set = q_rise & hit & ~rw_lvl & ~wb_free & ~wr_stall;
  assign cap_stall = wr_stall & wb_free & (q_fall | wr_qfell);
  assign capture   = cap_post | cap_stall;

  always_comb begin
    state_n     = state;
    rd_latch    = 1'b0;
    rd_mrdy_clr = 1'b0;
    rd_mrdy_set = 1'b0;
    spi_load    = 1'b0;
    oe_n        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (q_rise & hit & rw_lvl) begin
          rd_latch    = 1'b1;
          rd_mrdy_clr = 1'b1;
          state_n     = wb_free ? ST_RD_REQ : ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: if (wb_free) state_n = ST_RD_REQ;
      ST_RD_REQ:   if (accept & o_req_rw) state_n = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (rd_cmpl) begin
          spi_load    = 1'b1;
          rd_mrdy_set = 1'b1;
          oe_n        = e_lvl;
          state_n     = ST_RD_HOLD;
        end
      end
      ST_RD_HOLD: begin
        oe_n = e_lvl;
        if (!e_lvl) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      rd_addr       <= '0;
      wb_full       <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      wr_stall      <= 1'b0;
      wr_qfell      <= 1'b0;
      busy          <= 1'b0;
      busy_rw       <= 1'b0;
      cnt           <= '0;
      o_req_valid   <= 1'b0;
      o_req_rw      <= 1'b1;
      o_req_addr    <= '0;
      o_req_data    <= '0;
      o_spi_data    <= '0;
      o_data_oe     <= 1'b0;
      o_MemoryReady <= 1'b1;
      o_timeout     <= 1'b0;
    end else begin
      state <= state_n;
      if (rd_latch) rd_addr <= off;

      if (capture) begin
        wb_full <= 1'b1;
        wb_addr <= off;
        wb_data <= i_DataBus;
      end else if (wr_clear) begin
        wb_full <= 1'b0;
      end
      if (stall_set)      wr_stall <= 1'b1;
      else if (cap_stall) wr_stall <= 1'b0;
      wr_qfell <= wr_stall & ~cap_stall & (wr_qfell | q_fall);

      if (rd_mrdy_clr | stall_set)      o_MemoryReady <= 1'b0;
      else if (rd_mrdy_set | cap_stall) o_MemoryReady <= 1'b1;
      if (spi_load) o_spi_data <= done_ok ? i_rdata : TIMEOUT_FILL;
      o_data_oe <= oe_n;
      if (tmo_hit) o_timeout <= 1'b1;

      if (accept) begin
        o_req_valid <= 1'b0;
        busy        <= 1'b1;
        busy_rw     <= o_req_rw;
        cnt         <= '0;
      end else if (cmpl) begin
        busy <= 1'b0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end

      // The buffered write always goes out ahead of a waiting read.
      if (!o_req_valid && !busy) begin
        if (wb_full) begin
          o_req_valid <= 1'b1;
          o_req_rw    <= 1'b0;
          o_req_addr  <= FLASH_ADDR_W'(wb_addr);
          o_req_data  <= wb_data;
        end else if (state == ST_RD_REQ) begin
          o_req_valid <= 1'b1;
          o_req_rw    <= 1'b1;
          o_req_addr  <= FLASH_ADDR_W'(rd_addr);
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_bus_bridge.sv
// Directed bench for flash_bus_bridge: expected requests and read returns are
// queued by the stimulus and checked by an independent monitor.
module tb_flash_bus_bridge;
  import flash_bus_pkg::*;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_enable = 1'b0, i_Q = 1'b0, i_RW = 1'b1;
  logic [15:0] i_ADDRESS_BUS = 16'h0000;
  logic [7:0]  i_DataBus = 8'h00;
  logic        i_req_ready = 1'b0, i_done = 1'b0;
  logic [7:0]  i_rdata = 8'h00;
  logic        o_req_valid, o_req_rw, o_data_oe, o_MemoryReady, o_timeout;
  logic [23:0] o_req_addr;
  logic [7:0]  o_req_data, o_spi_data;

  flash_bus_bridge #(
    .BASE_ADDR(16'hE000), .WINDOW_BITS(12), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_Q(i_Q), .i_RW(i_RW),
    .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_DataBus(i_DataBus),
    .o_req_valid(o_req_valid), .o_req_rw(o_req_rw), .o_req_addr(o_req_addr),
    .o_req_data(o_req_data), .i_req_ready(i_req_ready), .i_done(i_done),
    .i_rdata(i_rdata), .o_spi_data(o_spi_data), .o_data_oe(o_data_oe),
    .o_MemoryReady(o_MemoryReady), .o_timeout(o_timeout));

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [32:0] req_q[$];
  logic [7:0]  rd_q[$];
  logic        mprev = 1'b1;
  logic        seen, stable;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!o_req_valid && k < budget) begin cyc(1); k++; end
    check(name, o_req_valid, 1);
  endtask

  task automatic accept();
    i_req_ready = 1'b1; cyc(1); i_req_ready = 1'b0;
  endtask

  task automatic done_pulse(input logic [7:0] d);
    i_done = 1'b1; i_rdata = d; cyc(1); i_done = 1'b0;
  endtask

  task automatic cpu_start(input logic [15:0] a, input logic rw, input logic [7:0] d);
    i_ADDRESS_BUS = a; i_RW = rw; i_DataBus = d; i_enable = 1'b1;
    cyc(2); i_Q = 1'b1;
  endtask

  // Scoreboard monitor: compares every handshake and every MRDY release.
  initial begin
    logic [32:0] e;
    logic [7:0]  r;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (o_req_valid && i_req_ready) begin
          if (req_q.size() == 0) check("sb_req_unexpected", {o_req_rw, o_req_addr}, 0);
          else begin
            e = req_q.pop_front();
            if (e[32]) check("sb_req_rd", {o_req_rw, o_req_addr}, e[32:8]);
            else       check("sb_req_wr", {o_req_rw, o_req_addr, o_req_data}, e);
          end
        end
        if (o_MemoryReady && !mprev) begin
          if (rd_q.size() == 0) check("sb_rd_unexpected", o_spi_data, 0);
          else begin
            r = rd_q.pop_front();
            check("sb_rd_data", o_spi_data, r);
          end
        end
      end
      mprev = reset ? o_MemoryReady : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    check("rst_valid", o_req_valid, 0);
    check("rst_rw", o_req_rw, 1);
    check("rst_addr_data", {o_req_addr, o_req_data}, 0);
    check("rst_spi_oe", {o_spi_data, o_data_oe}, 0);
    check("rst_mrdy_to", {o_MemoryReady, o_timeout}, 2'b10);
    reset = 1'b1;
    cyc(3);

    // Read hit at E123 returning 5A
    req_q.push_back({1'b1, 24'h000123, 8'h00});
    cpu_start(16'hE123, 1'b1, 8'h00);
    cyc(2); check("rd_mrdy_pre", o_MemoryReady, 1);
    cyc(1); check("rd_mrdy_fall", o_MemoryReady, 0);
    check("rd_req_not_yet", o_req_valid, 0);
    cyc(1); check("rd_req_valid", o_req_valid, 1);
    accept();
    cyc(3); check("rd_mrdy_held", o_MemoryReady, 0);
    rd_q.push_back(8'h5A);
    done_pulse(8'h5A);
    check("rd_mrdy_release", o_MemoryReady, 1);
    check("rd_spi_data", o_spi_data, 8'h5A);
    check("rd_oe_on", o_data_oe, 1);
    i_Q = 1'b0; cyc(2); i_enable = 1'b0;
    cyc(2); check("rd_oe_hold", o_data_oe, 1);
    cyc(1); check("rd_oe_efall", o_data_oe, 0);
    cyc(2);

    // Window miss, read then write
    cpu_start(16'hD123, 1'b1, 8'h00);
    seen = 1'b0;
    repeat (6) begin cyc(1); if (o_req_valid || !o_MemoryReady) seen = 1'b1; end
    i_Q = 1'b0; cyc(2); i_enable = 1'b0; cyc(2);
    check("miss_rd_quiet", seen, 0);
    cpu_start(16'hD123, 1'b0, 8'h33);
    seen = 1'b0;
    cyc(2); i_Q = 1'b0;
    repeat (8) begin cyc(1); if (o_req_valid || !o_MemoryReady) seen = 1'b1; end
    i_enable = 1'b0; cyc(3);
    check("miss_wr_quiet", seen, 0);

    // Posted write A5 to E010 with a 20-cycle ready stall
    req_q.push_back({1'b0, 24'h000010, 8'hA5});
    cpu_start(16'hE010, 1'b0, 8'hA5);
    cyc(2); i_Q = 1'b0;
    wait_valid("wr_req_valid", 8);
    i_enable = 1'b0; cyc(1);
    i_DataBus = 8'h00; i_ADDRESS_BUS = 16'h0000; i_RW = 1'b1;
    stable = 1'b1; seen = 1'b0;
    repeat (20) begin
      cyc(1);
      if ({o_req_valid, o_req_rw, o_req_addr, o_req_data} !== {2'b10, 24'h000010, 8'hA5}) stable = 1'b0;
      if (!o_MemoryReady) seen = 1'b1;
    end
    check("wr_stall_stable", stable, 1);
    check("wr_mrdy_never_low", seen, 0);
    accept();
    done_pulse(8'h00);
    cyc(2); check("wr_idle_after_done", o_req_valid, 0);

    // Write 3C to E020, then a read of E456 while the write is in flight
    req_q.push_back({1'b0, 24'h000020, 8'h3C});
    cpu_start(16'hE020, 1'b0, 8'h3C);
    cyc(2); i_Q = 1'b0;
    wait_valid("wr2_req_valid", 8);
    i_enable = 1'b0; cyc(2);
    accept();
    req_q.push_back({1'b1, 24'h000456, 8'h00});
    cpu_start(16'hE456, 1'b1, 8'h00);
    cyc(3); check("drain_mrdy_fall", o_MemoryReady, 0);
    cyc(5); check("drain_no_req", o_req_valid, 0);
    done_pulse(8'hEE);
    wait_valid("drain_rd_req", 6);
    accept();
    rd_q.push_back(8'h77);
    done_pulse(8'h77);
    check("drain_rd_data", o_spi_data, 8'h77);
    i_Q = 1'b0; cyc(2); i_enable = 1'b0; cyc(4);

    // Read with no i_done: timeout fill
    req_q.push_back({1'b1, 24'h000200, 8'h00});
    rd_q.push_back(8'hFF);
    cpu_start(16'hE200, 1'b1, 8'h00);
    wait_valid("to_req_valid", 8);
    accept();
    cyc(TO - 5);
    check("to_mrdy_held", o_MemoryReady, 0);
    check("to_flag_pre", o_timeout, 0);
    begin
      int k = 0;
      while (!o_MemoryReady && k < 20) begin cyc(1); k++; end
    end
    check("to_mrdy_release", o_MemoryReady, 1);
    check("to_flag", o_timeout, 1);
    check("to_fill", o_spi_data, TIMEOUT_FILL);
    i_Q = 1'b0; cyc(2); i_enable = 1'b0; cyc(10);
    check("to_sticky", o_timeout, 1);

    // Reset while waiting on a read, then a stray late i_done
    req_q.push_back({1'b1, 24'h000300, 8'h00});
    cpu_start(16'hE300, 1'b1, 8'h00);
    wait_valid("rst_rd_req", 8);
    accept();
    cyc(2); check("rst_wait_mrdy", o_MemoryReady, 0);
    reset = 1'b0; #1;
    check("arst_mrdy", o_MemoryReady, 1);
    check("arst_valid_rw", {o_req_valid, o_req_rw}, 2'b01);
    check("arst_addr_data", {o_req_addr, o_req_data}, 0);
    check("arst_spi", o_spi_data, 0);
    check("arst_timeout", o_timeout, 0);
    i_Q = 1'b0; i_enable = 1'b0; i_RW = 1'b1; i_ADDRESS_BUS = 16'h0000;
    cyc(3); reset = 1'b1; cyc(2);
    done_pulse(8'h99);
    cyc(2);
    check("late_done_spi", o_spi_data, 0);
    check("late_done_quiet", {o_req_valid, o_MemoryReady, o_data_oe}, 3'b010);

    check("sb_empty", req_q.size() + rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_bus_bridge.md
# flash_bus_bridge

Bus-side front end for the SPI flash controller. Synchronizes the 6809 E/Q/R-W strobes into `clk`, decodes the flash window, and issues single read or write requests to the SPI engine over a valid/ready + done handshake. Holds MRDY low (stretching the CPU cycle) until read data returns. Writes are posted through a one-entry buffer, with a timeout guard so a hung SPI engine cannot freeze the CPU.

## Interface
Parameters:
- BASE_ADDR, 16'hE000, window base (aligned to window size)
- WINDOW_BITS, 12, window size = 2^WINDOW_BITS bytes; address bits passed to flash
- SYNC_STAGES, 2, flip-flop depth for E/Q/R-W synchronizers (≥2)
- TIMEOUT_CYCLES, 1023, clk cycles from request accept to forced completion

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- i_enable  in  1  6809 E (asynchronous)
- i_Q  in  1  6809 Q (asynchronous)
- i_RW  in  1  6809 R/W, 1 = read
- i_ADDRESS_BUS  in  16  CPU address
- i_DataBus  in  8  CPU write data
- o_req_valid  out  1  request to SPI engine pending
- o_req_rw  out  1  1 = read, 0 = page-program byte
- o_req_addr  out  24  {zero-extend, addr[WINDOW_BITS-1:0]}
- o_req_data  out  8  write byte
- i_req_ready  in  1  engine accepts request when valid && ready
- i_done  in  1  one-cycle pulse, engine finished accepted request
- i_rdata  in  8  read byte, valid with i_done
- o_spi_data  out  8  read data to CPU bus
- o_data_oe  out  1  drive CPU data bus
- o_MemoryReady  out  1  MRDY to 6809; 0 = stretch
- o_timeout  out  1  sticky timeout flag

## Operation
- Reset values: o_req_valid=0, o_req_rw=1, o_req_addr=0, o_req_data=0, o_spi_data=0, o_data_oe=0, o_MemoryReady=1, o_timeout=0, state IDLE, write buffer empty.
- E, Q, and R/W pass through SYNC_STAGES FFs. Edge detect on the synchronized outputs. Address and data are sampled on the same cycle as the detected edge.
- hit = (i_ADDRESS_BUS[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS]).
- FSM states: IDLE, RD_DRAIN, RD_REQ, RD_WAIT, RD_HOLD.
- IDLE + Q-rise + hit + RW=1:
  - o_MemoryReady ← 0 and latch the address.
  - Go to RD_REQ if the write buffer is empty, else RD_DRAIN.
- RD_DRAIN: wait until the write buffer is empty, then go to RD_REQ.
- RD_REQ: assert o_req_valid with rw=1. On ready, go to RD_WAIT and start the timeout counter.
- RD_WAIT: on i_done, o_spi_data ← i_rdata, o_MemoryReady ← 1, go to RD_HOLD.
- RD_HOLD: o_data_oe=1 while synchronized E is high. On E-fall, o_data_oe ← 0 and return to IDLE.
- Write path runs in parallel with the read FSM and arbitrates ahead of it:
  - Q-fall + hit + RW=0 with buffer empty: capture address/data into the buffer; mark it full. MRDY is untouched (posted write).
  - Q-rise + hit + RW=0 with buffer full: o_MemoryReady ← 0. Capture is deferred to the first Q-fall seen after the buffer empties, then MRDY ← 1. The CPU holds address and data stable while stretched.
  - Buffer full: present the buffer on o_req_* with rw=0. After accept, wait for i_done, then mark empty.
- Only one request is outstanding at a time. o_req_* stay stable while valid && !ready.
- Timeout: the counter reaches TIMEOUT_CYCLES after accept without i_done:
  - Forced completion and o_timeout ← 1 (sticky until reset).
  - A read returns 8'hFF with MRDY released. A write drops the buffer.
- i_done with nothing outstanding is ignored.
- Reset mid-operation: immediate return to reset values. The pending write is discarded.

## Timing
- Read MRDY fall: SYNC_STAGES+1 clk after raw Q rise (window hit, buffer empty).
- Read request: o_req_valid asserts 1 clk after MRDY fall.
- Read completion: o_spi_data and MRDY=1 are registered 1 clk after i_done.
- Posted write: o_req_valid asserts 1 clk after buffer capture.
- Simultaneous same-cycle events: i_done for a write and a read Q-rise in the same cycle → the buffer empties that cycle and the read proceeds to RD_REQ next cycle, with no extra RD_DRAIN cycle.
- Timeout counter width: clog2(TIMEOUT_CYCLES+1). It counts only while a request is outstanding and clears on accept.

## Structure
- Shared package `flash_bus_pkg`: FSM state enum, `FLASH_CMD_*` opcodes, 24-bit address width, and the timeout-fill byte 8'hFF. These are shared with the SPI engine.
- Sub-module `bus_sync_edge`: one per strobe. Parameterized synchronizer plus rise/fall pulse outputs.

## Test plan
- Read hit at 16'hE123: engine returns 8'h5A → o_req_addr=24'h000123, rw=1; MRDY low until 1 clk after i_done; o_spi_data=8'h5A; oe drops at E-fall.
- Miss at 16'hD123 (read and write) → no o_req_valid; MRDY stays 1.
- Write 8'hA5 to 16'hE010: ready held low 20 clk → MRDY never drops; o_req_* stable through the stall; data=8'hA5, addr=24'h000010.
- Write followed by read while the write is outstanding → read enters RD_DRAIN; read request issued only after the write's i_done.
- No i_done on a read → after TIMEOUT_CYCLES, o_spi_data=8'hFF, MRDY=1, o_timeout=1 until reset.
- Reset asserted in RD_WAIT → all outputs at reset values asynchronously; a late i_done after reset is ignored.
